// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : sequential ALU with a valid/ready handshake on both sides.
//
// Accepts one operation at a time from the issue stage. Single-cycle opcodes
// have their result registered on the accept edge. MUL, DIVU and REMU iterate
// one bit per cycle for WIDTH cycles. DIVU/REMU with a zero divisor skip the
// iterative phase. Every result is held until the writeback stage takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation presented by the issue stage
//   in_ready   block can accept an operation (depends on state and out_ready)
//   x, y       operands A and B (WIDTH bits)
//   control    5-bit opcode (0..14 legal, 15..31 illegal)
//   cin        carry-in, used by ADDC only
//   out_valid  result registered and presented
//   out_ready  writeback stage takes the result
//   result     registered result
//   overflow   signed overflow (ADD/ADDC/SUB only)
//   carry      carry-out / not-borrow (ADD/ADDC/SUB only)
//   zero       registered result equals zero
//   err        illegal opcode or divide-by-zero
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [4:0]       control,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd6;
    localparam logic [4:0] OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8;
    localparam logic [4:0] OP_SRA  = 5'd9;
    localparam logic [4:0] OP_SLT  = 5'd10;
    localparam logic [4:0] OP_SLTU = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd12;
    localparam logic [4:0] OP_DIVU = 5'd13;
    localparam logic [4:0] OP_REMU = 5'd14;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE   = SHW'(1);

    state_t           state_r;
    logic [4:0]       op_r;
    logic [WIDTH-1:0] a_r;        // MUL accumulator / DIV partial remainder
    logic [WIDTH-1:0] b_r;        // MUL multiplicand / DIV dividend->quotient
    logic [WIDTH-1:0] c_r;        // MUL multiplier / DIV divisor
    logic [SHW-1:0]   cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             overflow_r;
    logic             carry_r;
    logic             zero_r;
    logic             err_r;
    logic             out_valid_r;

    logic             accept_s;
    logic [WIDTH-1:0] addend_s;
    logic             cin_eff_s;
    logic [WIDTH:0]   sum_s;
    logic             arith_ovf_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;
    logic             alu_cry_s;
    logic             alu_err_s;
    logic             multi_s;

    logic [WIDTH-1:0] mul_acc_s;
    logic [WIDTH:0]   div_trial_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH-1:0] iter_a_s;
    logic [WIDTH-1:0] iter_b_s;
    logic [WIDTH-1:0] iter_c_s;
    logic [WIDTH-1:0] final_s;

    // Ready in IDLE, or in DONE when the held result is being taken this edge.
    assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign err       = err_r;

    // Single-cycle datapath and classification of the presented opcode.
    always_comb begin
        addend_s  = y;
        cin_eff_s = 1'b0;
        if (control == OP_SUB) begin
            // Subtraction as x + ~y + 1 so carry reads as not-borrow.
            addend_s  = ~y;
            cin_eff_s = 1'b1;
        end else if (control == OP_ADDC) begin
            addend_s  = y;
            cin_eff_s = cin;
        end else begin
            addend_s  = y;
            cin_eff_s = 1'b0;
        end
        sum_s       = {1'b0, x} + {1'b0, addend_s} + {{WIDTH{1'b0}}, cin_eff_s};
        arith_ovf_s = (x[WIDTH-1] == addend_s[WIDTH-1]) && (sum_s[WIDTH-1] != x[WIDTH-1]);
        shamt_s     = y[SHW-1:0];

        alu_res_s = '0;
        alu_ovf_s = 1'b0;
        alu_cry_s = 1'b0;
        alu_err_s = 1'b0;
        multi_s   = 1'b0;
        case (control)
            OP_ADD, OP_ADDC, OP_SUB: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_ovf_s = arith_ovf_s;
                alu_cry_s = sum_s[WIDTH];
            end
            OP_AND:  alu_res_s = x & y;
            OP_OR:   alu_res_s = x | y;
            OP_XOR:  alu_res_s = x ^ y;
            OP_NOT:  alu_res_s = ~x;
            OP_SLL:  alu_res_s = x << shamt_s;
            OP_SRL:  alu_res_s = x >> shamt_s;
            OP_SRA:  alu_res_s = $signed(x) >>> shamt_s;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_MUL:  multi_s   = 1'b1;
            OP_DIVU: begin
                if (y == '0) begin
                    alu_res_s = '1;
                    alu_err_s = 1'b1;
                end else begin
                    multi_s = 1'b1;
                end
            end
            OP_REMU: begin
                if (y == '0) begin
                    alu_res_s = x;
                    alu_err_s = 1'b1;
                end else begin
                    multi_s = 1'b1;
                end
            end
            default: begin
                alu_res_s = '0;
                alu_err_s = 1'b1;
            end
        endcase
    end

    // One shift-add or restoring-divide step on the working registers.
    always_comb begin
        mul_acc_s   = a_r + (c_r[0] ? b_r : '0);
        div_trial_s = {a_r, b_r[WIDTH-1]};
        div_ge_s    = (div_trial_s >= {1'b0, c_r});
        // The remainder is always below the divisor, so WIDTH bits suffice.
        div_rem_s   = div_ge_s ? (div_trial_s[WIDTH-1:0] - c_r) : div_trial_s[WIDTH-1:0];
        if (op_r == OP_MUL) begin
            iter_a_s = mul_acc_s;
            iter_b_s = {b_r[WIDTH-2:0], 1'b0};
            iter_c_s = {1'b0, c_r[WIDTH-1:1]};
        end else begin
            iter_a_s = div_rem_s;
            iter_b_s = {b_r[WIDTH-2:0], div_ge_s};
            iter_c_s = c_r;
        end
        if (op_r == OP_DIVU) begin
            final_s = iter_b_s;
        end else begin
            final_s = iter_a_s;
        end
    end

    // Control FSM, iterative datapath and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= 5'd0;
            a_r         <= '0;
            b_r         <= '0;
            c_r         <= '0;
            cnt_r       <= '0;
            result_r    <= '0;
            overflow_r  <= 1'b0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        // Covers back-to-back: the held result retires on this edge.
                        op_r  <= control;
                        a_r   <= '0;
                        b_r   <= x;
                        c_r   <= y;
                        cnt_r <= '0;
                        if (multi_s) begin
                            state_r     <= BUSY;
                            out_valid_r <= 1'b0;
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= alu_res_s;
                            overflow_r  <= alu_ovf_s;
                            carry_r     <= alu_cry_s;
                            zero_r      <= (alu_res_s == '0);
                            err_r       <= alu_err_s;
                        end
                    end else if ((state_r == DONE) && out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                        out_valid_r <= out_valid_r;
                    end
                end
                BUSY: begin
                    a_r   <= iter_a_s;
                    b_r   <= iter_b_s;
                    c_r   <= iter_c_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_ITER) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= final_s;
                        overflow_r  <= 1'b0;
                        carry_r     <= 1'b0;
                        zero_r      <= (final_s == '0);
                        err_r       <= 1'b0;
                    end else begin
                        state_r     <= BUSY;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq at WIDTH=32 and WIDTH=8.
// Both instances see the same stimulus; sel picks the one being checked.
// Expected values come from an arithmetic reference model (ref_op).
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  control;
    logic        cin;
    logic        out_ready;
    logic        sel;
    int          cur_w;

    logic        rdy32, val32, ovf32, cy32, z32, e32;
    logic [31:0] res32;
    logic        rdy8, val8, ovf8, cy8, z8, e8;
    logic [7:0]  res8;

    logic        obs_ready, obs_valid, obs_ovf, obs_cy, obs_zero, obs_err;
    logic [31:0] obs_res;

    int n_cmp;
    int n_fail;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .x(x), .y(y), .control(control), .cin(cin),
        .out_valid(val32), .out_ready(out_ready), .result(res32),
        .overflow(ovf32), .carry(cy32), .zero(z32), .err(e32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
        .x(x[7:0]), .y(y[7:0]), .control(control), .cin(cin),
        .out_valid(val8), .out_ready(out_ready), .result(res8),
        .overflow(ovf8), .carry(cy8), .zero(z8), .err(e8)
    );

    assign obs_ready = sel ? rdy8 : rdy32;
    assign obs_valid = sel ? val8 : val32;
    assign obs_res   = sel ? {24'h0, res8} : res32;
    assign obs_ovf   = sel ? ovf8 : ovf32;
    assign obs_cy    = sel ? cy8 : cy32;
    assign obs_zero  = sel ? z8 : z32;
    assign obs_err   = sel ? e8 : e32;

    // Directed table: opcode, 32-bit operands, 8-bit operands, carry-in.
    localparam int ND = 17;
    localparam logic [4:0]  T_OP  [ND] = '{5'd0, 5'd1, 5'd2, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14,
                                           5'd13, 5'd14, 5'd20, 5'd7, 5'd8, 5'd3, 5'd5, 5'd6};
    localparam logic [31:0] T_X32 [ND] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF,
                                           32'hFFFFFFFF, 32'd12345, 32'd100, 32'd100, 32'hDEADBEEF,
                                           32'hDEADBEEF, 32'd1234, 32'h00000081, 32'h80000001,
                                           32'hF0F0A5A5, 32'hF0F0A5A5, 32'h0F0F1234};
    localparam logic [31:0] T_Y32 [ND] = '{32'd1, 32'd0, 32'd7, 32'd4, 32'd1, 32'd1, 32'd678, 32'd7, 32'd7,
                                           32'd0, 32'd0, 32'd5678, 32'h23, 32'h21,
                                           32'h0FF0FFFF, 32'h0FF0FFFF, 32'd0};
    localparam logic [31:0] T_X8  [ND] = '{32'h7F, 32'hFF, 32'd5, 32'h80, 32'hFF, 32'hFF, 32'd12, 32'd100,
                                           32'd100, 32'h5A, 32'h5A, 32'd12, 32'h81, 32'h81,
                                           32'hF5, 32'hF5, 32'h3C};
    localparam logic [31:0] T_Y8  [ND] = '{32'd1, 32'd0, 32'd7, 32'd4, 32'd1, 32'd1, 32'd13, 32'd7, 32'd7,
                                           32'd0, 32'd0, 32'd34, 32'h0B, 32'h09,
                                           32'h3C, 32'h3C, 32'd0};
    localparam logic        T_CI  [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reference model: opcode semantics in plain integer arithmetic at width w.
    function automatic void ref_op(input int w, input logic [4:0] op, input logic [31:0] xa,
                                   input logic [31:0] ya, input logic ci, output logic [31:0] r,
                                   output logic ov, output logic cy, output logic er);
        longint unsigned mask, xu, yu, s;
        longint sx, sy, sd, lo, hi;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        xu = {32'h0, xa} & mask;
        yu = {32'h0, ya} & mask;
        sx = ((xu >> (w - 1)) & 64'd1) != 64'd0 ? longint'(xu) - (longint'(1) << w) : longint'(xu);
        sy = ((yu >> (w - 1)) & 64'd1) != 64'd0 ? longint'(yu) - (longint'(1) << w) : longint'(yu);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        sh = int'(yu % longint'(w));
        r = 32'h0; ov = 1'b0; cy = 1'b0; er = 1'b0;
        case (op)
            5'd0, 5'd1: begin
                s  = xu + yu + ((op == 5'd1) ? {63'h0, ci} : 64'd0);
                sd = sx + sy + ((op == 5'd1) ? longint'(ci) : 0);
                r  = 32'(s & mask);
                cy = (s > mask);
                ov = (sd < lo) || (sd > hi);
            end
            5'd2: begin
                r  = 32'((xu - yu) & mask);
                cy = (xu >= yu);
                sd = sx - sy;
                ov = (sd < lo) || (sd > hi);
            end
            5'd3:  r = 32'(xu & yu);
            5'd4:  r = 32'(xu | yu);
            5'd5:  r = 32'(xu ^ yu);
            5'd6:  r = 32'(~xu & mask);
            5'd7:  r = 32'((xu << sh) & mask);
            5'd8:  r = 32'(xu >> sh);
            5'd9:  r = 32'(longint'(sx >>> sh) & longint'(mask));
            5'd10: r = (sx < sy) ? 32'd1 : 32'd0;
            5'd11: r = (xu < yu) ? 32'd1 : 32'd0;
            5'd12: r = 32'((xu * yu) & mask);
            5'd13: begin
                if (yu == 64'd0) begin r = 32'(mask); er = 1'b1; end
                else r = 32'(xu / yu);
            end
            5'd14: begin
                if (yu == 64'd0) begin r = 32'(xu); er = 1'b1; end
                else r = 32'(xu % yu);
            end
            default: er = 1'b1;
        endcase
    endfunction

    function automatic int exp_latency(input int w, input logic [4:0] op, input logic [31:0] ya);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
        if (op == 5'd12 || ((op == 5'd13 || op == 5'd14) && (ya & m) != 32'd0)) return w + 1;
        return 1;
    endfunction

    // Presents an operation and waits (bounded) for the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] xa, input logic [31:0] ya,
                         input logic ci, output bit ok);
        control = op; x = xa; y = ya; cin = ci; in_valid = 1'b1;
        ok = 1'b0;
        #1;
        for (int k = 0; k < 100; k++) begin
            if (obs_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = $urandom; y = $urandom; control = 5'($urandom); cin = 1'($urandom);
    endtask

    // Counts cycles from the accept edge until out_valid is seen on a falling edge.
    task automatic wait_valid(input bit ok, output int lat, output bit rdy_seen);
        lat = 0; rdy_seen = 1'b0;
        if (!ok) begin lat = -1; return; end
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (obs_valid) break;
            if (obs_ready) rdy_seen = 1'b1;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = 32'h0; y = 32'h0; control = 5'd0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs_ready, obs_valid, obs_res, obs_ovf, obs_cy, obs_zero, obs_err} !== {2'b10, 32'h0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset w=%0d: got rdy=%b val=%b res=%h flags=%b%b%b%b, expected rdy=1 val=0 res=0 flags=0000",
                     cur_w, obs_ready, obs_valid, obs_res, obs_ovf, obs_cy, obs_zero, obs_err);
        end
        do_reset();
    endtask

    task automatic test_directed();
        bit ok, rs;
        int lat, el;
        logic [31:0] er_r;
        logic eo, ec, ee;
        for (int i = 0; i < ND; i++) begin
            logic [31:0] xa, ya;
            xa = (cur_w == 32) ? T_X32[i] : T_X8[i];
            ya = (cur_w == 32) ? T_Y32[i] : T_Y8[i];
            ref_op(cur_w, T_OP[i], xa, ya, T_CI[i], er_r, eo, ec, ee);
            el = exp_latency(cur_w, T_OP[i], ya);
            issue(T_OP[i], xa, ya, T_CI[i], ok);
            wait_valid(ok, lat, rs);
            n_cmp++;
            if (lat != el) begin
                n_fail++;
                $display("FAIL latency w=%0d op=%0d: got %0d expected %0d", cur_w, T_OP[i], lat, el);
            end
            if (el > 1) begin
                n_cmp++;
                if (rs !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_ready w=%0d op=%0d: in_ready seen 1 while busy, expected 0", cur_w, T_OP[i]);
                end
            end
            n_cmp++;
            if ({obs_res, obs_ovf, obs_cy, obs_zero, obs_err} !== {er_r, eo, ec, (er_r == 32'h0), ee}) begin
                n_fail++;
                $display("FAIL directed w=%0d op=%0d x=%h y=%h: got res=%h o/c/z/e=%b%b%b%b expected res=%h o/c/z/e=%b%b%b%b",
                         cur_w, T_OP[i], xa, ya, obs_res, obs_ovf, obs_cy, obs_zero, obs_err,
                         er_r, eo, ec, (er_r == 32'h0), ee);
            end
            retire();
            n_cmp++;
            if ({obs_valid, obs_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL retire w=%0d op=%0d: got val/rdy=%b%b expected 01", cur_w, T_OP[i], obs_valid, obs_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok, rs;
        int lat;
        logic [31:0] r1, r2, r3;
        logic o1, c1, e1, o2, c2, e2, o3, c3, e3;
        logic [31:0] xa;
        xa = $urandom;
        ref_op(cur_w, 5'd0, xa, 32'd3, 1'b0, r1, o1, c1, e1);
        issue(5'd0, xa, 32'd3, 1'b0, ok);
        wait_valid(ok, lat, rs);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({obs_valid, obs_ready, obs_res, obs_ovf, obs_cy, obs_zero, obs_err} !== {2'b10, r1, o1, c1, (r1 == 32'h0), e1}) begin
                n_fail++;
                $display("FAIL hold w=%0d cyc=%0d: got val/rdy=%b%b res=%h expected val/rdy=10 res=%h",
                         cur_w, i, obs_valid, obs_ready, obs_res, r1);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_ready w=%0d: got in_ready=%b expected 1", cur_w, obs_ready);
        end
        ref_op(cur_w, 5'd5, 32'h5A5AC3C3, 32'h0F0F0F0F, 1'b0, r2, o2, c2, e2);
        issue(5'd5, 32'h5A5AC3C3, 32'h0F0F0F0F, 1'b0, ok);
        out_ready = 1'b0;
        wait_valid(ok, lat, rs);
        n_cmp++;
        if (lat != 1 || obs_res !== r2) begin
            n_fail++;
            $display("FAIL b2b w=%0d: got lat=%0d res=%h expected lat=1 res=%h", cur_w, lat, obs_res, r2);
        end
        ref_op(cur_w, 5'd12, 32'd12345, 32'd678, 1'b0, r3, o3, c3, e3);
        out_ready = 1'b1;
        issue(5'd12, 32'd12345, 32'd678, 1'b0, ok);
        out_ready = 1'b0;
        wait_valid(ok, lat, rs);
        n_cmp++;
        if (lat != cur_w + 1 || obs_res !== r3 || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_mul w=%0d: got lat=%0d res=%h expected lat=%0d res=%h",
                     cur_w, lat, obs_res, cur_w + 1, r3);
        end
        retire();
    endtask

    task automatic test_reset_mid();
        bit ok, rs;
        int lat;
        logic [31:0] r;
        logic o, c, e;
        issue(5'd13, 32'hFFFF_FFF0, 32'd3, 1'b0, ok);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs_valid, obs_ready, obs_res, obs_ovf, obs_cy, obs_zero, obs_err} !== {2'b01, 32'h0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_mid w=%0d: got val/rdy=%b%b res=%h expected val/rdy=01 res=0",
                     cur_w, obs_valid, obs_ready, obs_res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ref_op(cur_w, 5'd0, 32'd40, 32'd2, 1'b0, r, o, c, e);
        issue(5'd0, 32'd40, 32'd2, 1'b0, ok);
        wait_valid(ok, lat, rs);
        n_cmp++;
        if (lat != 1 || obs_res !== r || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset w=%0d: got lat=%0d res=%h expected lat=1 res=%h", cur_w, lat, obs_res, r);
        end
        retire();
    endtask

    task automatic test_random();
        bit ok, rs;
        int lat, el;
        logic [31:0] r, xa, ya;
        logic o, c, e, ci;
        logic [4:0] op;
        for (int i = 0; i < 50; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
            xa = $urandom;
            case ($urandom_range(0, 3))
                0:       ya = 32'h0;
                1:       ya = $urandom_range(1, 9);
                default: ya = $urandom;
            endcase
            ci = 1'($urandom);
            ref_op(cur_w, op, xa, ya, ci, r, o, c, e);
            el = exp_latency(cur_w, op, ya);
            issue(op, xa, ya, ci, ok);
            wait_valid(ok, lat, rs);
            n_cmp++;
            if (lat != el || {obs_res, obs_ovf, obs_cy, obs_zero, obs_err} !== {r, o, c, (r == 32'h0), e}) begin
                n_fail++;
                $display("FAIL random w=%0d op=%0d x=%h y=%h cin=%b: got lat=%0d res=%h o/c/z/e=%b%b%b%b expected lat=%0d res=%h o/c/z/e=%b%b%b%b",
                         cur_w, op, xa, ya, ci, lat, obs_res, obs_ovf, obs_cy, obs_zero, obs_err,
                         el, r, o, c, (r == 32'h0), e);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            retire();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        sel    = 1'b0;
        cur_w  = 32;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel   = (s == 1);
            cur_w = (s == 1) ? 8 : 32;
            test_reset();
            test_directed();
            test_backpressure();
            test_reset_mid();
            test_random();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential successor to the 32-bit combinational ALU.
- Registers operands and results behind a valid/ready handshake.
- Adds multi-cycle multiply, unsigned divide and remainder (shift-add / restoring, one bit per cycle) plus status flags.
- Sits between the instruction-issue stage and the writeback stage: accepts one operation at a time and holds each result until writeback takes it.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- SHW, $clog2(WIDTH), number of shift-amount bits taken from y.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- control  in  5  opcode.
- cin  in  1  carry-in, used by ADDC only.
- out_valid  out  1  result registered and presented.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result.
- overflow  out  1  signed overflow (ADD/ADDC/SUB only, else 0).
- carry  out  1  carry-out / not-borrow (ADD/ADDC/SUB only, else 0).
- zero  out  1  result == 0.
- err  out  1  illegal opcode or divide-by-zero.

Behaviour:
- Reset (rst_n low, any time, including mid-divide): state IDLE; in_ready=1; out_valid=0; result, overflow, carry, zero and err all 0. Any in-flight operation is discarded.
- Opcodes:
  - 0 ADD x+y
  - 1 ADDC x+y+cin
  - 2 SUB x-y
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT x
  - 7 SLL x<<y[SHW-1:0]
  - 8 SRL
  - 9 SRA (arithmetic)
  - 10 SLT (signed x<y → 1, else 0)
  - 11 SLTU
  - 12 MUL (low WIDTH bits of x*y)
  - 13 DIVU quotient
  - 14 REMU remainder
  - 15..31 illegal: result 0, err=1, other flags 0.
- Carry and overflow:
  - carry = bit WIDTH of the (WIDTH+1)-bit sum; for SUB it is x+~y+1.
  - overflow = operand signs equal and result sign differs (for SUB, using ~y).
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready. Operands and opcode are captured on that edge; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1.
    - On accept of opcode 12–14 (non-zero divisor for 13/14) → BUSY, iteration counter = 0.
    - On accept of any other opcode → DONE, with result registered on the same edge (latency 1: out_valid high the cycle after accept).
  - BUSY: in_ready=0. One iteration per cycle; after WIDTH iterations → DONE. Latency from accept edge to out_valid = WIDTH+1 cycles.
  - DONE: out_valid=1; result and flags held stable while out_ready=0.
    - out_ready=1 and in_valid=0 → IDLE.
    - in_ready = out_ready in DONE. Simultaneous out_ready=1 and in_valid=1 hands off the old result and accepts the new operation on the same edge (back-to-back, no bubble). Next state follows the IDLE rules.
- Divide by zero (13/14, y=0): no BUSY phase; latency 1; err=1. DIVU result = all ones; REMU result = x.
- MUL overflow beyond WIDTH bits is silently truncated; flags other than zero are 0.
- zero is computed from the final registered result for every opcode, including illegal ones (zero=1 there).
- No combinational path from inputs to result or flags. in_ready depends only on state and out_ready.

Test Plan:
- Reset mid-op: start DIVU, pull rst_n low at iteration 10 → out_valid=0, in_ready=1 immediately (async); a new ADD completes normally afterwards.
- ADD (WIDTH=32): x=0x7FFFFFFF, y=1 → one cycle later result=0x80000000, overflow=1, carry=0. ADDC: x=0xFFFFFFFF, y=0, cin=1 → result=0, carry=1, zero=1.
- Shifts and compares: SRA x=0x80000000, y=4 → 0xF8000000; SLT x=-1, y=1 → 1; SLTU same operands → 0.
- Multi-cycle: MUL x=12345, y=678 → result=8369910 exactly 33 cycles after accept, in_ready=0 throughout. DIVU x=100, y=7 → 14; REMU → 2. DIVU y=0 → 0xFFFFFFFF, err=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a result → result and flags stable, in_ready=0. Then assert out_ready and in_valid together → old result retired, new op accepted with no bubble cycle.
- Illegal opcode 20 → result=0, err=1, zero=1. Repeat all scenarios at WIDTH=8 (MUL latency 9).
